edge_window_ctrl: RTL

Frame sequencer and output gate for the 3x3 horizontal-edge datapath. It tracks pixel column and row from the camera frame and data valids, and suppresses edge results until both line buffers and the column shift registers hold a full window. It tags each valid result with its window-centre coordinate and applies a per-frame magnitude threshold. It sits between the edge-detect stage and the downstream frame writer, and reports frame completion and short-frame errors.

---
 rtl/edge_window_if.sv | 28 ++
 rtl/edge_window_ctrl.sv | 113 +++++++++++
 2 files changed

// File: rtl/edge_window_if.sv
// Pixel-stream bundle between the edge-detect stage, the window controller and the frame writer.
// Valid-only stream, no backpressure: iDVAL qualifies iEdge, oDVAL qualifies oEdge/oX/oY; both are consumed on every cycle they are high.
interface edge_window_if #(
    parameter int CW = 11
);
    logic          iFVAL;
    logic          iDVAL;
    logic [11:0]   iEdge;
    logic [11:0]   iThresh;
    logic          iThreshWe;
    logic [11:0]   oEdge;
    logic          oDVAL;
    logic [CW-1:0] oX;
    logic [CW-1:0] oY;
    logic          oFrameDone;
    logic          oBusy;
    logic          oErr;

    modport master (
        output iFVAL, iDVAL, iEdge, iThresh, iThreshWe,
        input  oEdge, oDVAL, oX, oY, oFrameDone, oBusy, oErr
    );

    modport slave (
        input  iFVAL, iDVAL, iEdge, iThresh, iThreshWe,
        output oEdge, oDVAL, oX, oY, oFrameDone, oBusy, oErr
    );
endinterface

// File: rtl/edge_window_ctrl.sv
// Frame sequencer for the 3x3 edge datapath: counts pixels, gates results until the window is full,
// tags results with window-centre coordinates and applies a per-frame shadowed threshold.
module edge_window_ctrl #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int CW         = 11
) (
    input  logic         iCLK,
    input  logic         iRST,
    edge_window_if.slave win,
    output logic [1:0]   dbg_state
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam logic [CW-1:0] X_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] Y_LAST = CW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] ONE    = CW'(1);
    localparam logic [CW-1:0] TWO    = CW'(2);

    state_t        state, state_nxt;
    logic [CW-1:0] x, y, x_nxt, y_nxt;
    logic          fval_d;
    logic [11:0]   thr_pend, thr_act;
    logic          frame_start, last_col;
    logic          res_valid, done_nxt, err_nxt;

    assign frame_start = win.iFVAL && !fval_d;
    assign last_col    = (x == X_LAST);
    assign win.oBusy   = (state != IDLE);
    assign dbg_state   = state;

    always_comb begin
        state_nxt = state;
        x_nxt     = x;
        y_nxt     = y;
        res_valid = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = win.oErr;
        case (state)
            IDLE: begin
                x_nxt = '0;
                y_nxt = '0;
                if (frame_start) begin
                    state_nxt = PRIME;
                    err_nxt   = 1'b0;
                    // A pixel arriving with the frame-start cycle is pixel (0,0).
                    if (win.iDVAL) x_nxt = ONE;
                end
            end
            PRIME, ACTIVE: begin
                if (!win.iFVAL) begin
                    // Frame ended early; any pixel in this cycle is dropped.
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                    x_nxt     = '0;
                    y_nxt     = '0;
                end else if (win.iDVAL) begin
                    res_valid = (state == ACTIVE) && (x >= TWO);
                    if (last_col) begin
                        x_nxt = '0;
                        y_nxt = y + ONE;
                        if (state == PRIME && y == ONE) state_nxt = ACTIVE;
                        if (state == ACTIVE && y == Y_LAST) begin
                            done_nxt  = 1'b1;
                            state_nxt = IDLE;
                            y_nxt     = '0;
                        end
                    end else begin
                        x_nxt = x + ONE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state          <= IDLE;
            x              <= '0;
            y              <= '0;
            fval_d         <= 1'b0;
            thr_pend       <= '0;
            thr_act        <= '0;
            win.oEdge      <= '0;
            win.oDVAL      <= 1'b0;
            win.oX         <= '0;
            win.oY         <= '0;
            win.oFrameDone <= 1'b0;
            win.oErr       <= 1'b0;
        end else begin
            state          <= state_nxt;
            x              <= x_nxt;
            y              <= y_nxt;
            fval_d         <= win.iFVAL;
            win.oDVAL      <= res_valid;
            win.oFrameDone <= done_nxt;
            win.oErr       <= err_nxt;
            if (win.iThreshWe) thr_pend <= win.iThresh;
            // The active threshold only changes at frame start, so mid-frame writes wait a frame.
            if (frame_start) thr_act <= win.iThreshWe ? win.iThresh : thr_pend;
            if (res_valid) begin
                win.oEdge <= (win.iEdge >= thr_act) ? win.iEdge : 12'd0;
                win.oX    <= x - ONE;
                win.oY    <= y - ONE;
            end
        end
    end
endmodule
